// File: rtl/hdmi_fb_pattern_writer.sv
// AXI4 write master that fills the HDMI framebuffer with an 8-bar colour-bar pattern.
// Optional macro PATWR_BRESP_CHK_EN: a non-OKAY bresp sets err_o and aborts the fill.
module hdmi_fb_pattern_writer #(
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = 32,
    parameter int                ID_W       = 4,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
    parameter int                FB_WORDS   = 1024,
    parameter int                BURST_LEN  = 16,
    parameter int                LINE_WORDS = 64,
    parameter int                BAR_W      = 8
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              start_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [ID_W-1:0]   m_axi_awid,
    output logic [ADDR_W-1:0] m_axi_awaddr,
    output logic [7:0]        m_axi_awlen,
    output logic [2:0]        m_axi_awsize,
    output logic [1:0]        m_axi_awburst,
    output logic              m_axi_awvalid,
    input  logic              m_axi_awready,
    output logic [DATA_W-1:0] m_axi_wdata,
    output logic [3:0]        m_axi_wstrb,
    output logic              m_axi_wlast,
    output logic              m_axi_wvalid,
    input  logic              m_axi_wready,
    input  logic [ID_W-1:0]   m_axi_bid,
    input  logic [1:0]        m_axi_bresp,
    input  logic              m_axi_bvalid,
    output logic              m_axi_bready
);

    typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [31:0]         word_cnt_q, word_cnt_d;
    logic [8:0]          beat_q, beat_d;
    logic [31:0]         col_q, col_d;
    logic [31:0]         barw_q, barw_d;
    logic [2:0]          bar_q, bar_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                wlast_q, wlast_d;
    logic                done_q, done_d;
    logic                load_pat;
    logic                unused_ok;

    function automatic logic [15:0] rom_f(input logic [2:0] idx);
        case (idx)
            3'd0:    rom_f = 16'hEB80;
            3'd1:    rom_f = 16'hD292;
            3'd2:    rom_f = 16'hAA10;
            3'd3:    rom_f = 16'h9122;
            3'd4:    rom_f = 16'h6ADE;
            3'd5:    rom_f = 16'h51F0;
            3'd6:    rom_f = 16'h296E;
            default: rom_f = 16'h1080;
        endcase
    endfunction

`ifdef PATWR_BRESP_CHK_EN
    logic err_q, err_d;
    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        beat_d     = beat_q;
        col_d      = col_q;
        barw_d     = barw_q;
        bar_d      = bar_q;
        wdata_d    = wdata_q;
        wlast_d    = wlast_q;
        done_d     = done_q;
        load_pat   = 1'b0;
`ifdef PATWR_BRESP_CHK_EN
        err_d      = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d    = S_AW;
                    word_cnt_d = '0;
                    col_d      = '0;
                    barw_d     = '0;
                    bar_d      = '0;
                    done_d     = 1'b0;
`ifdef PATWR_BRESP_CHK_EN
                    err_d      = 1'b0;
`endif
                end
            end
            S_AW: begin
                if (m_axi_awready) begin
                    state_d  = S_W;
                    beat_d   = '0;
                    wlast_d  = (BURST_LEN == 1);
                    load_pat = 1'b1;
                end
            end
            S_W: begin
                if (m_axi_wready) begin
                    if (wlast_q) begin
                        state_d = S_B;
                        wlast_d = 1'b0;
                    end else begin
                        beat_d   = beat_q + 9'd1;
                        wlast_d  = (beat_q + 9'd1 == 9'(BURST_LEN - 1));
                        load_pat = 1'b1;
                    end
                end
            end
            S_B: begin
                if (m_axi_bvalid) begin
                    word_cnt_d = word_cnt_q + 32'(BURST_LEN);
`ifdef PATWR_BRESP_CHK_EN
                    if (m_axi_bresp != 2'b00) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else
`endif
                    if (word_cnt_d >= 32'(FB_WORDS)) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_AW;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Pattern counters always point at the next word to be loaded into wdata_q.
        if (load_pat) begin
            wdata_d = DATA_W'({rom_f(bar_q), rom_f(bar_q)});
            if (col_q == 32'(LINE_WORDS - 1)) begin
                col_d  = '0;
                barw_d = '0;
                bar_d  = '0;
            end else begin
                col_d = col_q + 32'd1;
                if (barw_q == 32'(BAR_W - 1)) begin
                    barw_d = '0;
                    bar_d  = bar_q + 3'd1;
                end else begin
                    barw_d = barw_q + 32'd1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q    <= S_IDLE;
            word_cnt_q <= '0;
            beat_q     <= '0;
            col_q      <= '0;
            barw_q     <= '0;
            bar_q      <= '0;
            wdata_q    <= '0;
            wlast_q    <= 1'b0;
            done_q     <= 1'b0;
`ifdef PATWR_BRESP_CHK_EN
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            beat_q     <= beat_d;
            col_q      <= col_d;
            barw_q     <= barw_d;
            bar_q      <= bar_d;
            wdata_q    <= wdata_d;
            wlast_q    <= wlast_d;
            done_q     <= done_d;
`ifdef PATWR_BRESP_CHK_EN
            err_q      <= err_d;
`endif
        end
    end

    assign busy_o        = (state_q != S_IDLE);
    assign done_o        = done_q;
    assign m_axi_awid    = '0;
    assign m_axi_awvalid = (state_q == S_AW);
    assign m_axi_awaddr  = m_axi_awvalid ? BASE_ADDR + ADDR_W'(word_cnt_q << 2) : '0;
    assign m_axi_awlen   = 8'(BURST_LEN - 1);
    assign m_axi_awsize  = 3'b010;
    assign m_axi_awburst = 2'b01;
    assign m_axi_wvalid  = (state_q == S_W);
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wlast   = wlast_q;
    assign m_axi_wstrb   = m_axi_wvalid ? 4'hF : 4'h0;
    assign m_axi_bready  = (state_q == S_B);
    assign unused_ok     = ^{m_axi_bid, m_axi_bresp};

endmodule

// File: tb/tb_hdmi_fb_pattern_writer.sv
// Bench for hdmi_fb_pattern_writer: AXI slave model with memory image and scoreboard queues.
// Handshake rule: a transfer occurs at a rising edge where valid and ready are both high.
module tb_hdmi_fb_pattern_writer;
    localparam int FB_WORDS   = 32;
    localparam int BURST_LEN  = 8;
    localparam int LINE_WORDS = 8;
    localparam int BAR_W      = 1;
    localparam logic [31:0] BASE = 32'h0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start;
    logic        busy, done, err;
    logic [3:0]  awid, bid;
    logic [31:0] awaddr, wdata;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst, bresp;
    logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic [3:0]  wstrb;

    hdmi_fb_pattern_writer #(
        .ADDR_W(32), .DATA_W(32), .ID_W(4), .BASE_ADDR(BASE), .FB_WORDS(FB_WORDS),
        .BURST_LEN(BURST_LEN), .LINE_WORDS(LINE_WORDS), .BAR_W(BAR_W)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .busy_o(busy), .done_o(done), .err_o(err),
        .m_axi_awid(awid), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen), .m_axi_awsize(awsize),
        .m_axi_awburst(awburst), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
        .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast), .m_axi_wvalid(wvalid),
        .m_axi_wready(wready), .m_axi_bid(bid), .m_axi_bresp(bresp), .m_axi_bvalid(bvalid),
        .m_axi_bready(bready)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    logic [31:0] exp_q[$];
    logic [31:0] exp_aw_q[$];
    logic [31:0] mem [FB_WORDS];

    function automatic logic [15:0] rom_ref(input int i);
        logic [15:0] tbl [8];
        tbl = '{16'hEB80, 16'hD292, 16'hAA10, 16'h9122, 16'h6ADE, 16'h51F0, 16'h296E, 16'h1080};
        return tbl[i];
    endfunction

    function automatic logic [31:0] pat_ref(input int w);
        int col, bar;
        col = w % LINE_WORDS;
        bar = (col / BAR_W) % 8;
        return {rom_ref(bar), rom_ref(bar)};
    endfunction

    // Slave model state
    bit          bp_en = 0;
    int          aw_delay = 0;
    int          err_burst = -1;
    int          aw_wait, aw_count, b_count, w_beat, cur_word, done_rises;
    bit          stall_prev, b_pending, b_hs_prev, done_prev;
    logic [31:0] stall_data;

    initial begin
        awready = 0; wready = 0; bvalid = 0; bresp = 2'b00; bid = 4'h0;
    end

    // Ready/valid for the next rising edge are set here, then the resulting handshakes are scored.
    always @(negedge clk) begin
        if (!rst_n) begin
            awready = 0; wready = 0; bvalid = 0; bresp = 2'b00;
            aw_wait = 0; w_beat = 0; stall_prev = 0; b_pending = 0; b_hs_prev = 0; done_prev = 0;
        end else begin
            if (awvalid) begin
                awready = (aw_wait >= aw_delay);
                aw_wait++;
            end else begin
                awready = 0;
                aw_wait = 0;
            end
            if (awvalid && awready) begin
                check_eq("aw_has_exp", 32'(exp_aw_q.size() != 0), 1);
                if (exp_aw_q.size() != 0) check_eq("awaddr", awaddr, exp_aw_q.pop_front());
                check_eq("awlen", 32'(awlen), BURST_LEN - 1);
                cur_word = int'((awaddr - BASE) >> 2);
                w_beat = 0;
                aw_count++;
                aw_wait = 0;
            end

            if (stall_prev) begin
                check_eq("wvalid_hold", 32'(wvalid), 1);
                check_eq("wdata_hold", wdata, stall_data);
            end
            wready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
            if (wvalid && wready) begin
                check_eq("w_has_exp", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) check_eq("wdata", wdata, exp_q.pop_front());
                check_eq("wlast", 32'(wlast), 32'(w_beat == BURST_LEN - 1));
                check_eq("wstrb", 32'(wstrb), 32'hF);
                if (cur_word >= 0 && cur_word < FB_WORDS) mem[cur_word] = wdata;
                cur_word++;
                w_beat++;
                if (wlast) b_pending = 1;
            end
            stall_prev = wvalid && !wready;
            stall_data = wdata;

            if (b_hs_prev) begin
                bvalid = 0;
                b_hs_prev = 0;
            end
            if (b_pending && !bvalid) begin
                bvalid = 1;
                bresp = (b_count == err_burst) ? 2'b10 : 2'b00;
                b_pending = 0;
            end
            if (bvalid && bready) begin
                b_hs_prev = 1;
                b_count++;
            end

            if (done && !done_prev) done_rises++;
            done_prev = done;
        end
    end

    task automatic clear_stats();
        aw_count = 0; b_count = 0; done_rises = 0;
        for (int i = 0; i < FB_WORDS; i++) mem[i] = 32'h0;
    endtask

    task automatic push_fill(input int n_bursts);
        for (int b = 0; b < n_bursts; b++) begin
            exp_aw_q.push_back(BASE + 32'(b * BURST_LEN * 4));
            for (int k = 0; k < BURST_LEN; k++) exp_q.push_back(pat_ref(b * BURST_LEN + k));
        end
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1;
        @(negedge clk) start = 0;
    endtask

    task automatic wait_done(input string tag);
        int k;
        k = 0;
        while (!(done && !busy) && k < 2000) begin
            @(negedge clk); #1;
            k++;
        end
        check_eq({tag, "_done_timeout"}, 32'(k < 2000), 1);
        @(negedge clk); #1;
    endtask

    task automatic wait_beat(input int burst_no, input int beat_no);
        int k;
        k = 0;
        while (!(aw_count == burst_no && w_beat == beat_no) && k < 2000) begin
            @(negedge clk); #1;
            k++;
        end
        check_eq("beat_wait_timeout", 32'(k < 2000), 1);
    endtask

    task automatic check_fill(input string tag, input int n_bursts, input logic exp_err);
        check_eq({tag, "_aw_count"}, aw_count, n_bursts);
        check_eq({tag, "_b_count"}, b_count, n_bursts);
        check_eq({tag, "_done_rises"}, done_rises, 1);
        check_eq({tag, "_done"}, 32'(done), 1);
        check_eq({tag, "_busy"}, 32'(busy), 0);
        check_eq({tag, "_err"}, 32'(err), 32'(exp_err));
        check_eq({tag, "_exp_q_left"}, exp_q.size(), 0);
        check_eq({tag, "_exp_aw_left"}, exp_aw_q.size(), 0);
        for (int w = 0; w < FB_WORDS; w++)
            check_eq({tag, "_mem"}, mem[w], (w < n_bursts * BURST_LEN) ? pat_ref(w) : 32'h0);
    endtask

    initial begin
        rst_n = 0;
        start = 0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1;
        check_eq("rst_awvalid", 32'(awvalid), 0);
        check_eq("rst_wvalid", 32'(wvalid), 0);
        check_eq("rst_bready", 32'(bready), 0);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_done", 32'(done), 0);
        check_eq("rst_err", 32'(err), 0);
        check_eq("rst_awlen", 32'(awlen), BURST_LEN - 1);
        check_eq("rst_awsize", 32'(awsize), 32'd2);
        check_eq("rst_awburst", 32'(awburst), 32'd1);
        check_eq("rst_wstrb", 32'(wstrb), 0);

        // Full fill without backpressure
        clear_stats();
        push_fill(4);
        pulse_start();
        check_eq("start_busy", 32'(busy), 1);
        wait_done("fill");
        check_fill("fill", 4, 1'b0);

        // Random wready, awready delayed by 5 cycles
        bp_en = 1;
        aw_delay = 5;
        clear_stats();
        push_fill(4);
        pulse_start();
        check_eq("bp_done_cleared", 32'(done), 0);
        wait_done("bp");
        check_fill("bp", 4, 1'b0);
        bp_en = 0;
        aw_delay = 0;

        // start_i pulsed mid-burst is ignored
        clear_stats();
        push_fill(4);
        pulse_start();
        wait_beat(2, 3);
        check_eq("busy_mid", 32'(busy), 1);
        pulse_start();
        wait_done("busy_start");
        check_fill("busy_start", 4, 1'b0);

        // SLVERR on the second burst
        err_burst = 1;
        clear_stats();
`ifdef PATWR_BRESP_CHK_EN
        push_fill(2);
        pulse_start();
        wait_done("errp");
        check_fill("errp", 2, 1'b1);
`else
        push_fill(4);
        pulse_start();
        wait_done("errp");
        check_fill("errp", 4, 1'b0);
`endif
        err_burst = -1;

        // Reset at beat 3 of the first burst, then a clean restart
        clear_stats();
        push_fill(4);
        pulse_start();
        wait_beat(1, 3);
        #1 rst_n = 0;
        @(posedge clk); #2;
        check_eq("mid_rst_awvalid", 32'(awvalid), 0);
        check_eq("mid_rst_wvalid", 32'(wvalid), 0);
        check_eq("mid_rst_bready", 32'(bready), 0);
        check_eq("mid_rst_busy", 32'(busy), 0);
        @(negedge clk) rst_n = 1;
        exp_q.delete();
        exp_aw_q.delete();
        clear_stats();
        push_fill(4);
        pulse_start();
        wait_done("restart");
        check_fill("restart", 4, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
